// File: rtl/vgac_pkg.sv
// vgac_pkg: shared pixel/SRAM widths, grant encoding and SRAM address packing
package vgac_pkg;
    localparam int PIXEL_W = 16;
    localparam int COORD_W = 10;
    localparam int SRAM_ADDR_W = 20;
    typedef enum logic [1:0] {
        GRANT_IDLE,
        GRANT_READ,
        GRANT_WRITE,
        GRANT_FORCE
    } grant_e;
    function automatic logic [SRAM_ADDR_W-1:0] pack_addr(
        input logic [COORD_W-1:0] y,
        input logic [COORD_W-1:0] x
    );
        return {y, x};
    endfunction
endpackage

// File: rtl/sram_wr_fifo.sv
// sram_wr_fifo: synchronous write-buffer FIFO with occupancy count
module sram_wr_fifo #(
    parameter int W = 36,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic do_push;
    logic do_pop;
    always_comb begin
        full = level == (AW+1)'(DEPTH);
        empty = level == '0;
        do_push = push && !full;
        do_pop = pop && !empty;
        dout = mem[rd_ptr];
    end
    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM port between never-stalling pixel reads and FIFO-buffered capture writes
module sram_arbiter
    import vgac_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = PIXEL_W,
    parameter int READ_LATENCY = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int FORCE_LEVEL = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rd_req,
    input  logic [COORD_W-1:0]          rd_x,
    input  logic [COORD_W-1:0]          rd_y,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        rd_valid,
    output logic                        rd_skip,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [COORD_W-1:0]          wr_x,
    input  logic [COORD_W-1:0]          wr_y,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        mem_re,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 drop_count,
    output logic [15:0]                 skip_count
);
    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic [ADDR_W+DATA_W-1:0] head;
    grant_e grant;
    grant_e grant_q;
    logic [1:0] tag [READ_LATENCY+1];
    assign wr_ready = !fifo_full;
    assign pop = grant == GRANT_WRITE || grant == GRANT_FORCE;
    sram_wr_fifo #(
        .W     (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_valid && wr_ready),
        .pop   (pop),
        .din   ({pack_addr(wr_y, wr_x), wr_data}),
        .dout  (head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
    always_ff @(posedge clk) begin
        if (rst) grant_q <= GRANT_IDLE;
        else grant_q <= grant;
    end
    always_comb begin
        grant = !fifo_empty && int'(fifo_level) >= FORCE_LEVEL ? GRANT_FORCE :
                rd_req ? GRANT_READ :
                !fifo_empty ? GRANT_WRITE : GRANT_IDLE;
    end
    always_comb begin
        mem_re = grant_q == GRANT_READ;
        mem_we = grant_q == GRANT_WRITE || grant_q == GRANT_FORCE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr <= '0;
            mem_wdata <= '0;
        end else if (grant == GRANT_READ) begin
            mem_addr <= pack_addr(rd_y, rd_x);
        end else if (pop) begin
            mem_addr <= head[ADDR_W+DATA_W-1:DATA_W];
            mem_wdata <= head[DATA_W-1:0];
        end
    end
    // tag = {serviced, skipped}; the extra stage lines the tag up with mem_rdata
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= READ_LATENCY; i++) tag[i] <= '0;
            rd_valid <= 1'b0;
            rd_skip <= 1'b0;
            rd_data <= '0;
            skip_count <= '0;
            drop_count <= '0;
        end else begin
            tag[0] <= {grant == GRANT_READ, rd_req && grant == GRANT_FORCE};
            for (int i = 1; i <= READ_LATENCY; i++) tag[i] <= tag[i-1];
            rd_valid <= tag[READ_LATENCY][1];
            rd_skip <= tag[READ_LATENCY][0];
            if (tag[READ_LATENCY][1]) rd_data <= mem_rdata;
            if (tag[READ_LATENCY][0] && skip_count != '1) skip_count <= skip_count + 1'b1;
            if (wr_valid && !wr_ready && drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized lockstep check of sram_arbiter against a queue-based reference model
module tb_sram_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, rd_req, wr_valid;
    logic [9:0] rd_x, rd_y, wr_x, wr_y;
    logic [15:0] wr_data, mem_rdata, rd_data, mem_wdata, drop_count, skip_count;
    logic rd_valid, rd_skip, wr_ready, mem_re, mem_we;
    logic [19:0] mem_addr;
    logic [3:0] fifo_level;
    logic rd_valid9, rd_skip9, wr_ready9, mem_re9, mem_we9;
    logic [15:0] rd_data9, mem_wdata9, drop_count9, skip_count9;
    logic [19:0] mem_addr9;
    logic [3:0] fifo_level9;
    logic [15:0] zero16 = '0;
    int tests = 0;
    int fails = 0;

    sram_arbiter dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_skip(rd_skip),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .fifo_level(fifo_level), .drop_count(drop_count), .skip_count(skip_count)
    );

    // Same stimulus, forcing disabled so the FIFO can fill behind a solid read stream
    sram_arbiter #(.FORCE_LEVEL(9)) dut9 (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y),
        .rd_data(rd_data9), .rd_valid(rd_valid9), .rd_skip(rd_skip9),
        .wr_valid(wr_valid), .wr_ready(wr_ready9), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .mem_re(mem_re9), .mem_we(mem_we9), .mem_addr(mem_addr9), .mem_wdata(mem_wdata9),
        .mem_rdata(zero16), .fifo_level(fifo_level9), .drop_count(drop_count9), .skip_count(skip_count9)
    );

    function automatic logic [15:0] init_val(logic [19:0] a);
        return a == 20'h01C05 ? 16'hABCD : a[15:0] ^ 16'h5A5A;
    endfunction

    // SRAM behind sram_interface: data appears READ_LATENCY cycles after mem_re is seen
    logic [15:0] sram [logic [19:0]];
    logic [15:0] p1, p2;
    always @(posedge clk) begin
        p1 <= sram.exists(mem_addr) ? sram[mem_addr] : init_val(mem_addr);
        p2 <= p1;
        mem_rdata <= p2;
        if (mem_we) sram[mem_addr] = mem_wdata;
    end

    typedef struct {
        int due;
        bit ok;
        logic [15:0] d;
    } ret_t;
    logic [35:0] mq[$];
    ret_t pend[$];
    logic [15:0] mmem [logic [19:0]];
    int cyc = 0;
    logic e_re, e_we, e_valid, e_skip, e_ready;
    logic [19:0] e_addr;
    logic [15:0] e_wdata, e_rdata, e_skipc, e_dropc;
    logic [3:0] e_level;

    function automatic logic [92:0] obs();
        return {rd_valid, rd_skip, rd_data, mem_re, mem_we, mem_addr, mem_wdata,
                wr_ready, fifo_level, skip_count, drop_count};
    endfunction

    function automatic logic [92:0] expv();
        return {e_valid, e_skip, e_rdata, e_re, e_we, e_addr, e_wdata,
                e_ready, e_level, e_skipc, e_dropc};
    endfunction

    // Apply the arbitration rules to the current inputs, then advance one clock
    task automatic tick();
        int lvl;
        bit frc, rd, wr;
        logic [35:0] h;
        ret_t r;
        lvl = mq.size();
        frc = lvl >= 6;
        rd = rd_req && !frc;
        wr = frc || (!rd_req && lvl > 0);
        if (rst) begin
            mq.delete();
            pend.delete();
            e_re = 0; e_we = 0; e_valid = 0; e_skip = 0;
            e_addr = '0; e_wdata = '0; e_rdata = '0; e_skipc = '0; e_dropc = '0;
        end else begin
            e_re = rd; e_we = wr; e_valid = 0; e_skip = 0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                r = pend.pop_front();
                e_valid = r.ok;
                e_skip = !r.ok;
                if (r.ok) e_rdata = r.d;
                else if (e_skipc != 16'hFFFF) e_skipc++;
            end
            if (rd_req) begin
                r.due = cyc + 4;
                r.ok = rd;
                r.d = mmem.exists({rd_y, rd_x}) ? mmem[{rd_y, rd_x}] : init_val({rd_y, rd_x});
                pend.push_back(r);
                if (rd) e_addr = {rd_y, rd_x};
            end
            if (wr) begin
                h = mq.pop_front();
                e_addr = h[35:16];
                e_wdata = h[15:0];
                mmem[e_addr] = e_wdata;
            end
            if (wr_valid) begin
                if (lvl < 8) mq.push_back({wr_y, wr_x, wr_data});
                else if (e_dropc != 16'hFFFF) e_dropc++;
            end
        end
        e_level = 4'(mq.size());
        e_ready = mq.size() < 8;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        rd_x = 10'($urandom_range(0, 3));
        rd_y = 10'($urandom_range(0, 3));
        wr_x = 10'($urandom_range(0, 3));
        wr_y = 10'($urandom_range(0, 3));
        wr_data = 16'($urandom);
    endtask

    task automatic test_reset();
        rst = 1; rd_req = 0; wr_valid = 0;
        rd_x = 0; rd_y = 0; wr_x = 0; wr_y = 0; wr_data = 0;
        tick();
        tick();
        tests++;
        if (obs() !== {1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 20'h0, 16'h0, 1'b1, 4'h0, 16'h0, 16'h0}) begin
            fails++;
            $display("FAIL reset_state: got %h want all zero with wr_ready=1", obs());
        end
        rst = 0;
        wr_valid = 1;
        for (int i = 0; i < 4; i++) begin
            rd_req = i != 0;
            rand_inputs();
            tick();
        end
        tests++;
        if (fifo_level !== 4'd4) begin
            fails++;
            $display("FAIL reset_fill_level: got %0d want 4", fifo_level);
        end
        rst = 1; rd_req = 0; wr_valid = 0;
        tick();
        tests++;
        if (fifo_level !== 4'd0 || wr_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_midtraffic: level %0d ready %b want 0 1", fifo_level, wr_ready);
        end
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests++;
            if (rd_valid !== 1'b0 || rd_skip !== 1'b0) begin
                fails++;
                $display("FAIL reset_no_return: valid %b skip %b want 0 0", rd_valid, rd_skip);
            end
        end
    endtask

    task automatic test_read();
        rd_req = 1; rd_x = 10'd5; rd_y = 10'd7;
        tick();
        rd_req = 0;
        tests++;
        if ({mem_re, mem_we, mem_addr} !== {1'b1, 1'b0, 20'h01C05}) begin
            fails++;
            $display("FAIL read_issue: re %b we %b addr %h want 1 0 01c05", mem_re, mem_we, mem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (rd_valid !== (i == 3)) begin
                fails++;
                $display("FAIL read_latency: step %0d rd_valid %b want %b", i, rd_valid, i == 3);
            end
        end
        tests++;
        if (rd_data !== 16'hABCD || obs() !== expv()) begin
            fails++;
            $display("FAIL read_data: got %h want abcd (full %h vs %h)", rd_data, obs(), expv());
        end
    endtask

    task automatic test_idle_write();
        rd_req = 0; wr_valid = 1; wr_x = 10'd1; wr_y = 10'd2; wr_data = 16'h1234;
        tick();
        wr_valid = 0;
        tests++;
        if (fifo_level !== 4'd1 || mem_we !== 1'b0) begin
            fails++;
            $display("FAIL idle_write_push: level %0d we %b want 1 0", fifo_level, mem_we);
        end
        tick();
        tests++;
        if ({mem_we, mem_re, mem_addr, mem_wdata, fifo_level} !== {1'b1, 1'b0, 20'h00801, 16'h1234, 4'd0}) begin
            fails++;
            $display("FAIL idle_write_issue: we %b re %b addr %h data %h level %0d want 1 0 00801 1234 0",
                     mem_we, mem_re, mem_addr, mem_wdata, fifo_level);
        end
        tick();
        tests++;
        if (obs() !== expv()) begin
            fails++;
            $display("FAIL idle_write_model: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_continuous();
        rst = 1; rd_req = 0; wr_valid = 0;
        tick();
        rst = 0; rd_req = 1; wr_valid = 1;
        for (int i = 0; i < 11; i++) begin
            rand_inputs();
            tick();
            tests++;
            if (obs() !== expv()) begin
                fails++;
                $display("FAIL cont_model: step %0d got %h want %h", i, obs(), expv());
            end
            if (i < 6) begin
                tests++;
                if (fifo_level !== 4'(i + 1) || mem_re !== 1'b1) begin
                    fails++;
                    $display("FAIL cont_climb: step %0d level %0d re %b want %0d 1", i, fifo_level, mem_re, i + 1);
                end
            end else if (i == 6) begin
                tests++;
                if ({mem_re, mem_we, fifo_level} !== {1'b0, 1'b1, 4'd6}) begin
                    fails++;
                    $display("FAIL cont_force: re %b we %b level %0d want 0 1 6", mem_re, mem_we, fifo_level);
                end
            end else if (i < 10) begin
                tests++;
                if (rd_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL cont_order: step %0d rd_valid %b want 1", i, rd_valid);
                end
            end else begin
                tests++;
                if ({rd_valid, rd_skip, skip_count} !== {1'b0, 1'b1, 16'd1}) begin
                    fails++;
                    $display("FAIL cont_skip: valid %b skip %b count %0d want 0 1 1", rd_valid, rd_skip, skip_count);
                end
            end
        end
        for (int i = 0; i < 400; i++) begin
            rd_req = $urandom_range(0, 3) != 0;
            wr_valid = $urandom_range(0, 2) != 0;
            rand_inputs();
            tick();
            tests++;
            if (obs() !== expv()) begin
                fails++;
                $display("FAIL rand_model: step %0d got %h want %h", i, obs(), expv());
            end
            tests++;
            if (mem_re && mem_we) begin
                fails++;
                $display("FAIL rand_exclusive: re %b we %b want not both", mem_re, mem_we);
            end
        end
    endtask

    task automatic test_overflow();
        logic [35:0] off [10];
        rst = 1; rd_req = 0; wr_valid = 0;
        tick();
        rst = 0; rd_req = 1; wr_valid = 1;
        for (int i = 0; i < 10; i++) begin
            rand_inputs();
            off[i] = {wr_y, wr_x, wr_data};
            tick();
            tests++;
            if ({wr_ready9, fifo_level9, mem_we9} !== {i < 7, 4'(i < 8 ? i + 1 : 8), 1'b0}) begin
                fails++;
                $display("FAIL ovf_fill: step %0d ready %b level %0d we %b want %b %0d 0",
                         i, wr_ready9, fifo_level9, mem_we9, i < 7, i < 8 ? i + 1 : 8);
            end
        end
        tests++;
        if (drop_count9 !== 16'd2) begin
            fails++;
            $display("FAIL ovf_drops: got %0d want 2", drop_count9);
        end
        rd_req = 0; wr_valid = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests++;
            if ({mem_we9, mem_addr9, mem_wdata9, fifo_level9} !== {1'b1, off[i], 4'(7 - i)}) begin
                fails++;
                $display("FAIL ovf_drain: entry %0d we %b addr %h data %h level %0d want 1 %h %0d",
                         i, mem_we9, mem_addr9, mem_wdata9, fifo_level9, off[i], 7 - i);
            end
        end
        tick();
        tests++;
        if (mem_we9 !== 1'b0 || obs() !== expv()) begin
            fails++;
            $display("FAIL ovf_done: we %b want 0 (main %h vs %h)", mem_we9, obs(), expv());
        end
    endtask

    task automatic test_saturation();
        int n = 0;
        rst = 1; rd_req = 0; wr_valid = 0;
        tick();
        rst = 0; rd_req = 1; wr_valid = 1;
        while (e_skipc != 16'hFFFF && n < 70000) begin
            rand_inputs();
            tick();
            n++;
            tests++;
            if (obs() !== expv()) begin
                fails++;
                $display("FAIL sat_model: step %0d got %h want %h", n, obs(), expv());
            end
            if (e_skipc == 16'hFFFE && rd_skip) begin
                tests++;
                if (skip_count !== 16'hFFFE) begin
                    fails++;
                    $display("FAIL sat_preload: got %h want fffe", skip_count);
                end
            end
        end
        tests++;
        if (n >= 70000) begin
            fails++;
            $display("FAIL sat_timeout: model skip count %h after %0d cycles", e_skipc, n);
        end
        for (int i = 0; i < 20; i++) begin
            rand_inputs();
            tick();
            tests++;
            if (skip_count !== 16'hFFFF || rd_skip !== 1'b1) begin
                fails++;
                $display("FAIL sat_hold: count %h skip %b want ffff 1", skip_count, rd_skip);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_idle_write();
        test_continuous();
        test_overflow();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single SRAM port between two requesters: the pipeline foreground read requester and the foreground capture writer (ADC 1 path).
- Reads arrive every pixel cycle and must never stall; they get priority and a fixed-latency return.
- Writes are buffered in an internal FIFO and issued in idle cycles.
- A write is forced only when the FIFO is near full; the colliding read is then reported as skipped.
- Sits between the pipeline/capture logic and sram_interface.

Parameters:
- ADDR_W, 20, SRAM word address width ({y[9:0], x[9:0]}).
- DATA_W, 16, pixel width.
- READ_LATENCY, 3, cycles from mem_re to mem_rdata valid in sram_interface.
- FIFO_DEPTH, 8, write FIFO entries (power of 2).
- FORCE_LEVEL, 6, FIFO occupancy at or above which a pending write beats a read.

Ports:
- clk  in  1  system clock (gclk100 domain)
- rst  in  1  synchronous reset, active high
- rd_req  in  1  pipeline read request this cycle
- rd_x  in  10  requested pixel x
- rd_y  in  10  requested pixel y
- rd_data  out  16  read pixel
- rd_valid  out  1  rd_data valid (read serviced)
- rd_skip  out  1  read not serviced; pipeline substitutes background
- wr_valid  in  1  capture write offered
- wr_ready  out  1  FIFO can accept
- wr_x  in  10  write pixel x
- wr_y  in  10  write pixel y
- wr_data  in  16  write pixel
- mem_re  out  1  to sram_interface read_enable
- mem_we  out  1  to sram_interface write_enable
- mem_addr  out  20  to r_addr/w_addr (shared)
- mem_wdata  out  16  to data_in
- mem_rdata  in  16  from data_out[15:0]
- fifo_level  out  4  current occupancy (0..FIFO_DEPTH)
- drop_count  out  16  saturating count of writes offered while wr_ready=0
- skip_count  out  16  saturating count of rd_skip pulses

Behaviour:
- Reset: all outputs 0 except wr_ready=1. FIFO emptied, latency pipe cleared, counters 0. Requests in flight at reset are discarded; no rd_valid/rd_skip for them.
- Address packing: addr = {y, x}, for both reads and writes.
- FIFO:
  - Push when wr_valid && wr_ready.
  - wr_ready = (level < FIFO_DEPTH), registered from the current level.
  - Push and pop in the same cycle: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - wr_valid && !wr_ready: write dropped; drop_count += 1, saturating at 0xFFFF.
- Grant per cycle, evaluated on state at the clock edge; mem_* outputs are registered, so each grant issues 1 cycle later.
  - FORCE: level >= FORCE_LEVEL and level > 0. Pop the head and issue a write. If rd_req is also set, that read is skipped.
  - READ: rd_req and not FORCE. Issue mem_re with the read address.
  - WRITE: !rd_req and level > 0. Pop and issue mem_we.
  - IDLE: mem_re = mem_we = 0. mem_addr holds its last value.
  - mem_re and mem_we are never both 1.
- Read return:
  - A per-request tag shift register of length READ_LATENCY+1 carries {serviced, skipped}.
  - rd_valid or rd_skip is asserted exactly READ_LATENCY+1 cycles after rd_req is sampled.
  - rd_data is registered from mem_rdata on rd_valid; it holds otherwise.
  - Exactly one of rd_valid/rd_skip pulses per accepted rd_req, in request order.
  - skip_count increments saturating on each rd_skip.
- Coherency: a read to an address with a pending FIFO write returns the old SRAM contents. No forwarding; acceptable for video.
- Pipeline throughput: one read per cycle sustained. Write bandwidth equals the idle-cycle count plus forced slots.

Decomposition:
- Shared package vgac_pkg:
  - PIXEL_W = 16, COORD_W = 10, SRAM_ADDR_W = 20.
  - Address-pack function {y, x}.
- Natural sub-module: sram_wr_fifo. Synchronous FIFO with push/pop/level/full/empty, DEPTH parameter, same clk/rst.
- Arbiter FSM, latency tag pipe and counters stay in sram_arbiter.

Test Plan:
- Reset mid-traffic: assert rst with 3 reads in flight and 4 FIFO entries -> next cycle fifo_level=0, wr_ready=1, no rd_valid/rd_skip ever emitted for those reads.
- Read only: rd_req at x=5, y=7, SRAM model holds 0xABCD at 0x01C05 -> mem_re with mem_addr=0x01C05 1 cycle later; rd_valid=1, rd_data=0xABCD 4 cycles after the request.
- Idle write: rd_req=0, one write x=1, y=2, data=0x1234 -> mem_we, mem_addr=0x00801, mem_wdata=0x1234 within 2 cycles; fifo_level returns to 0.
- Continuous reads plus writes every cycle:
  - Level climbs to 6; the next grant is FORCE and that read returns rd_skip (not rd_valid); skip_count=1.
  - Order of valid/skip matches request order.
  - Never mem_re && mem_we.
- Overflow: rd_req held 1, FORCE_LEVEL set to 9 (force disabled), 10 writes offered -> wr_ready drops after 8 pushes; drop_count=2; FIFO contents later written in push order.
- Counter saturation: preload skip_count to 0xFFFE via 2 extra forced skips -> reads 0xFFFF and stays there.
